// File: rtl/rw_arbiter_locked_if.sv
// Bundle of the IF requester, MEM requester and shared rw-port signals.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface rw_arbiter_locked_if #(
   parameter int RW_DATA_WIDTH  = 64,
   parameter int AXI_DATA_WIDTH = 64
);
   logic                      if_valid;
   logic                      if_req;
   logic [63:0]               if_addr;
   logic [1:0]                if_size;
   logic                      if_ready;
   logic [RW_DATA_WIDTH-1:0]  if_data_read;
   logic [1:0]                if_resp;

   logic                      mem_valid;
   logic                      mem_req;
   logic [63:0]               mem_addr;
   logic [1:0]                mem_size;
   logic [RW_DATA_WIDTH-1:0]  mem_data_write;
   logic                      mem_ready;
   logic [RW_DATA_WIDTH-1:0]  mem_data_read;
   logic [1:0]                mem_resp;

   logic                      rw_valid;
   logic                      rw_ready;
   logic                      rw_req;
   logic [AXI_DATA_WIDTH-1:0] rw_addr;
   logic [1:0]                rw_size;
   logic [RW_DATA_WIDTH-1:0]  data_write;
   logic [RW_DATA_WIDTH-1:0]  data_read;
   logic [1:0]                rw_resp;
   logic [3:0]                rw_id;

   modport slave (
      input  if_valid, if_req, if_addr, if_size,
      output if_ready, if_data_read, if_resp,
      input  mem_valid, mem_req, mem_addr, mem_size, mem_data_write,
      output mem_ready, mem_data_read, mem_resp,
      output rw_valid, rw_req, rw_addr, rw_size, data_write, rw_id,
      input  rw_ready, data_read, rw_resp
   );

   modport master (
      output if_valid, if_req, if_addr, if_size,
      input  if_ready, if_data_read, if_resp,
      output mem_valid, mem_req, mem_addr, mem_size, mem_data_write,
      input  mem_ready, mem_data_read, mem_resp,
      input  rw_valid, rw_req, rw_addr, rw_size, data_write, rw_id,
      output rw_ready, data_read, rw_resp
   );
endinterface

// File: rtl/rw_arbiter_locked.sv
// Locking two-requester arbiter (IF, MEM) onto a single rw port, MEM-first with
// a bounded streak so a waiting IF request is never starved.
module rw_arbiter_locked #(
   parameter int  RW_DATA_WIDTH  = 64,
   parameter int  AXI_DATA_WIDTH = 64,
   parameter int  MAX_MEM_STREAK = 4,
   localparam int STREAK_W       = $clog2(MAX_MEM_STREAK + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   rw_arbiter_locked_if.slave  bus,
   output logic [1:0]          dbg_state,
   output logic [STREAK_W-1:0] dbg_streak
);

   // Handshake: a requester raises *_valid and holds its request until it sees a
   // one-cycle *_ready completion pulse. The arbiter holds rw_valid with stable
   // rw_* fields for the whole ownership; rw_ready is a one-cycle completion pulse
   // that releases the lock. rw_ready seen while idle is ignored.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_IF  = 2'd1,
      OWN_MEM = 2'd2
   } state_e;

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

   state_e                    state_q,  state_d;
   logic [STREAK_W-1:0]       streak_q, streak_d;
   logic                      req_q,    req_d;
   logic [AXI_DATA_WIDTH-1:0] addr_q,   addr_d;
   logic [1:0]                size_q,   size_d;
   logic [RW_DATA_WIDTH-1:0]  wdata_q,  wdata_d;

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      req_d    = req_q;
      addr_d   = addr_q;
      size_d   = size_q;
      wdata_d  = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_valid && ((streak_q < STREAK_MAX) || !bus.if_valid)) begin
               state_d = OWN_MEM;
               req_d   = bus.mem_req;
               addr_d  = AXI_DATA_WIDTH'(bus.mem_addr);
               size_d  = bus.mem_size;
               wdata_d = bus.mem_data_write;
               // The streak only measures how long IF has been kept waiting.
               if (bus.if_valid && (streak_q != STREAK_MAX)) begin
                  streak_d = streak_q + STREAK_W'(1);
               end
            end else if (bus.if_valid) begin
               state_d  = OWN_IF;
               streak_d = '0;
               req_d    = bus.if_req;
               addr_d   = AXI_DATA_WIDTH'(bus.if_addr);
               size_d   = bus.if_size;
               wdata_d  = '0;
            end
         end
         OWN_IF, OWN_MEM: begin
            if (bus.rw_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         streak_q <= '0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         wdata_q  <= wdata_d;
      end
   end

   assign bus.rw_valid   = (state_q == OWN_IF) || (state_q == OWN_MEM);
   assign bus.rw_id      = (state_q == OWN_MEM) ? 4'h1 : 4'h0;
   assign bus.rw_req     = req_q;
   assign bus.rw_addr    = addr_q;
   assign bus.rw_size    = size_q;
   assign bus.data_write = wdata_q;

   assign bus.if_ready      = (state_q == OWN_IF)  && bus.rw_ready;
   assign bus.mem_ready     = (state_q == OWN_MEM) && bus.rw_ready;
   assign bus.if_data_read  = bus.data_read;
   assign bus.mem_data_read = bus.data_read;
   assign bus.if_resp       = bus.rw_resp;
   assign bus.mem_resp      = bus.rw_resp;

   assign dbg_state  = state_q;
   assign dbg_streak = streak_q;

endmodule

// File: tb/tb_rw_arbiter_locked.sv
// Scoreboarded bench for rw_arbiter_locked: each ownership grant seen on the rw
// port is compared against the next expected grant pushed by the stimulus tasks.
module tb_rw_arbiter_locked;
   localparam int DW   = 64;
   localparam int AW   = 64;
   localparam int MAXS = 4;
   localparam int SW   = $clog2(MAXS + 1);
   localparam int EW   = 4 + 1 + 2 + AW + DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    dbg_state;
   logic [SW-1:0] dbg_streak;

   always #5 clk = ~clk;

   rw_arbiter_locked_if #(.RW_DATA_WIDTH(DW), .AXI_DATA_WIDTH(AW)) bus ();

   rw_arbiter_locked #(
      .RW_DATA_WIDTH (DW),
      .AXI_DATA_WIDTH(AW),
      .MAX_MEM_STREAK(MAXS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_streak(dbg_streak)
   );

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_errors = 0;

   function automatic logic [EW-1:0] pack(input logic [3:0] id, input logic req,
                                          input logic [1:0] size, input logic [AW-1:0] addr,
                                          input logic [DW-1:0] wdata);
      return {id, req, size, addr, wdata};
   endfunction

   // Scoreboard: a new ownership always starts after at least one idle cycle.
   logic          prev_valid = 1'b0;
   logic [EW-1:0] sb_obs;
   logic [EW-1:0] sb_exp;
   always @(negedge clk) begin
      if (bus.rw_valid && !prev_valid) begin
         sb_obs = {bus.rw_id, bus.rw_req, bus.rw_size, bus.rw_addr, bus.data_write};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL grant_unexpected got=%h", sb_obs);
         end else begin
            sb_exp = exp_q.pop_front();
            if (sb_obs !== sb_exp) begin
               n_errors++;
               $display("FAIL grant_sb got=%h exp=%h", sb_obs, sb_exp);
            end
         end
      end
      prev_valid <= bus.rw_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   task automatic wait_owner(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rw_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic start_ready(input logic [DW-1:0] dr, input logic [1:0] rs);
      @(posedge clk);
      #1;
      bus.rw_ready  = 1'b1;
      bus.data_read = dr;
      bus.rw_resp   = rs;
      @(negedge clk);
   endtask

   task automatic end_ready();
      @(posedge clk);
      #1;
      bus.rw_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.rw_ready = 1'b1;
      @(negedge clk);
      n_checks += 6;
      if (bus.rw_valid !== 1'b0)  begin n_errors++; $display("FAIL rst_rw_valid got=%b exp=0", bus.rw_valid); end
      if (bus.rw_id !== 4'h0)     begin n_errors++; $display("FAIL rst_rw_id got=%h exp=0", bus.rw_id); end
      if (dbg_state !== 2'd0)     begin n_errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
      if (dbg_streak !== '0)      begin n_errors++; $display("FAIL rst_streak got=%0d exp=0", dbg_streak); end
      if (bus.rw_addr !== '0)     begin n_errors++; $display("FAIL rst_rw_addr got=%h exp=0", bus.rw_addr); end
      if ({bus.if_ready, bus.mem_ready} !== 2'b00) begin
         n_errors++; $display("FAIL rst_readies got=%b exp=00", {bus.if_ready, bus.mem_ready});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.if_ready, bus.mem_ready, dbg_state} !== 4'b0000) begin
            n_errors++;
            $display("FAIL idle_ignores_ready got=%b exp=0000", {bus.if_ready, bus.mem_ready, dbg_state});
         end
      end
      @(posedge clk);
      #1 bus.rw_ready = 1'b0;
   endtask

   task automatic test_if_only();
      logic [DW-1:0] dr;
      @(posedge clk);
      #1;
      bus.if_valid = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = 64'h8000_0000;
      bus.if_size  = 2'b10;
      exp_q.push_back(pack(4'h0, 1'b0, 2'b10, 64'h8000_0000, '0));
      @(negedge clk);
      n_checks++;
      if (bus.rw_valid !== 1'b0) begin n_errors++; $display("FAIL if_latency got=%b exp=0", bus.rw_valid); end
      @(posedge clk);
      #1;
      bus.if_valid = 1'b0;
      bus.if_addr  = {$urandom, $urandom};
      @(negedge clk);
      n_checks += 3;
      if (bus.rw_valid !== 1'b1)            begin n_errors++; $display("FAIL if_rw_valid got=%b exp=1", bus.rw_valid); end
      if (bus.rw_addr !== 64'h8000_0000)    begin n_errors++; $display("FAIL if_rw_addr got=%h exp=80000000", bus.rw_addr); end
      if (dbg_state !== 2'd1)               begin n_errors++; $display("FAIL if_state got=%0d exp=1", dbg_state); end
      dr = {$urandom, $urandom};
      start_ready(dr, 2'b01);
      n_checks += 3;
      if ({bus.if_ready, bus.mem_ready} !== 2'b10) begin
         n_errors++; $display("FAIL if_ready_route got=%b exp=10", {bus.if_ready, bus.mem_ready});
      end
      if (bus.if_data_read !== dr) begin n_errors++; $display("FAIL if_data_read got=%h exp=%h", bus.if_data_read, dr); end
      if (bus.if_resp !== 2'b01)   begin n_errors++; $display("FAIL if_resp got=%b exp=01", bus.if_resp); end
      end_ready();
      @(negedge clk);
      n_checks++;
      if ({bus.rw_valid, bus.if_ready, bus.rw_id} !== 6'b0) begin
         n_errors++; $display("FAIL if_release got=%b exp=000000", {bus.rw_valid, bus.if_ready, bus.rw_id});
      end
   endtask

   task automatic test_mem_priority();
      bit            ok;
      logic [AW-1:0] a_if  = {$urandom, $urandom};
      logic [AW-1:0] a_mem = {$urandom, $urandom};
      logic [DW-1:0] w     = {$urandom, $urandom};
      logic [DW-1:0] dr    = {$urandom, $urandom};
      @(posedge clk);
      #1;
      bus.if_valid = 1'b1; bus.if_req = 1'b1; bus.if_addr = a_if; bus.if_size = 2'b00;
      bus.mem_valid = 1'b1; bus.mem_req = 1'b1; bus.mem_addr = a_mem; bus.mem_size = 2'b11;
      bus.mem_data_write = w;
      exp_q.push_back(pack(4'h1, 1'b1, 2'b11, a_mem, w));
      exp_q.push_back(pack(4'h0, 1'b1, 2'b00, a_if, '0));
      wait_owner(ok);
      n_checks += 3;
      if (!ok) begin n_errors++; $display("FAIL mem_prio_timeout got=0 exp=1"); end
      if (bus.rw_id !== 4'h1)    begin n_errors++; $display("FAIL mem_prio_id got=%h exp=1", bus.rw_id); end
      if (dbg_streak !== SW'(1)) begin n_errors++; $display("FAIL mem_prio_streak got=%0d exp=1", dbg_streak); end
      #1 bus.mem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.if_ready !== 1'b0) begin n_errors++; $display("FAIL mem_own_if_ready got=%b exp=0", bus.if_ready); end
      end
      start_ready(dr, 2'b10);
      n_checks += 3;
      if ({bus.if_ready, bus.mem_ready} !== 2'b01) begin
         n_errors++; $display("FAIL mem_ready_route got=%b exp=01", {bus.if_ready, bus.mem_ready});
      end
      if (bus.mem_data_read !== dr) begin n_errors++; $display("FAIL mem_data_read got=%h exp=%h", bus.mem_data_read, dr); end
      if (bus.mem_resp !== 2'b10)   begin n_errors++; $display("FAIL mem_resp got=%b exp=10", bus.mem_resp); end
      end_ready();
      wait_owner(ok);
      n_checks += 2;
      if (!ok || bus.rw_id !== 4'h0) begin n_errors++; $display("FAIL if_after_mem got=%b/%h exp=1/0", ok, bus.rw_id); end
      if (dbg_streak !== '0) begin n_errors++; $display("FAIL if_clears_streak got=%0d exp=0", dbg_streak); end
      #1 bus.if_valid = 1'b0;
      start_ready({$urandom, $urandom}, 2'b00);
      end_ready();
   endtask

   task automatic test_streak();
      bit            ok;
      bit            is_if;
      logic [SW-1:0] exp_s;
      logic [AW-1:0] a_if  = {$urandom, $urandom};
      logic [AW-1:0] a_mem = {$urandom, $urandom};
      logic [DW-1:0] w     = {$urandom, $urandom};
      @(posedge clk);
      #1;
      bus.if_valid = 1'b1; bus.if_req = 1'b0; bus.if_addr = a_if; bus.if_size = 2'b01;
      bus.mem_valid = 1'b1; bus.mem_req = 1'b1; bus.mem_addr = a_mem; bus.mem_size = 2'b10;
      bus.mem_data_write = w;
      for (int g = 0; g < 10; g++) begin
         if ((g % 5) == 4) exp_q.push_back(pack(4'h0, 1'b0, 2'b01, a_if, '0));
         else              exp_q.push_back(pack(4'h1, 1'b1, 2'b10, a_mem, w));
      end
      for (int g = 0; g < 10; g++) begin
         is_if = ((g % 5) == 4);
         exp_s = is_if ? SW'(0) : SW'((g % 5) + 1);
         wait_owner(ok);
         n_checks += 2;
         if (!ok || bus.rw_id !== (is_if ? 4'h0 : 4'h1)) begin
            n_errors++; $display("FAIL streak_grant_%0d got=%b/%h exp_if=%b", g, ok, bus.rw_id, is_if);
         end
         if (dbg_streak !== exp_s) begin
            n_errors++; $display("FAIL streak_count_%0d got=%0d exp=%0d", g, dbg_streak, exp_s);
         end
         if (g == 9) begin
            #1; bus.if_valid = 1'b0; bus.mem_valid = 1'b0;
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         start_ready({$urandom, $urandom}, 2'b00);
         n_checks++;
         if ({bus.if_ready, bus.mem_ready} !== {is_if, !is_if}) begin
            n_errors++; $display("FAIL streak_ready_%0d got=%b exp=%b", g, {bus.if_ready, bus.mem_ready}, {is_if, !is_if});
         end
         end_ready();
      end
   endtask

   task automatic test_lock();
      bit            ok;
      logic [DW-1:0] w = {$urandom, $urandom};
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b1; bus.mem_req = 1'b0; bus.mem_addr = 64'h100; bus.mem_size = 2'b01;
      bus.mem_data_write = w;
      exp_q.push_back(pack(4'h1, 1'b0, 2'b01, 64'h100, w));
      exp_q.push_back(pack(4'h0, 1'b1, 2'b11, 64'h300, '0));
      wait_owner(ok);
      n_checks += 2;
      if (!ok || bus.rw_addr !== 64'h100) begin n_errors++; $display("FAIL lock_grant got=%b/%h exp=1/100", ok, bus.rw_addr); end
      if (dbg_streak !== '0) begin n_errors++; $display("FAIL streak_hold got=%0d exp=0", dbg_streak); end
      #1;
      bus.mem_addr = 64'h200; bus.mem_req = 1'b1; bus.mem_size = 2'b10; bus.mem_data_write = ~w;
      bus.if_valid = 1'b1; bus.if_req = 1'b1; bus.if_addr = 64'h300; bus.if_size = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.rw_addr, bus.rw_id, bus.rw_req, bus.data_write} !== {64'h100, 4'h1, 1'b0, w}) begin
            n_errors++; $display("FAIL lock_hold_%0d got=%h/%h/%b exp=100/1/0", i, bus.rw_addr, bus.rw_id, bus.rw_req);
         end
      end
      #1 bus.mem_valid = 1'b0;
      start_ready({$urandom, $urandom}, 2'b00);
      n_checks++;
      if (bus.mem_ready !== 1'b1) begin n_errors++; $display("FAIL lock_release got=%b exp=1", bus.mem_ready); end
      end_ready();
      wait_owner(ok);
      n_checks++;
      if (!ok || bus.rw_addr !== 64'h300) begin n_errors++; $display("FAIL lock_next_if got=%b/%h exp=1/300", ok, bus.rw_addr); end
      #1 bus.if_valid = 1'b0;
      start_ready({$urandom, $urandom}, 2'b00);
      end_ready();
   endtask

   task automatic test_reset_mid();
      bit ok;
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b1; bus.mem_req = 1'b1; bus.mem_addr = 64'h400; bus.mem_size = 2'b11;
      bus.mem_data_write = '0;
      exp_q.push_back(pack(4'h1, 1'b1, 2'b11, 64'h400, '0));
      wait_owner(ok);
      n_checks++;
      if (!ok || dbg_state !== 2'd2) begin n_errors++; $display("FAIL rmid_own got=%b/%0d exp=1/2", ok, dbg_state); end
      bus.mem_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks += 2;
      if ({bus.rw_valid, dbg_state, bus.rw_id} !== 7'b0) begin
         n_errors++; $display("FAIL rmid_async got=%b/%0d/%h exp=0/0/0", bus.rw_valid, dbg_state, bus.rw_id);
      end
      if (bus.rw_addr !== '0) begin n_errors++; $display("FAIL rmid_addr got=%h exp=0", bus.rw_addr); end
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.rw_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.mem_ready, bus.if_ready, dbg_state} !== 4'b0) begin
            n_errors++; $display("FAIL rmid_no_ready got=%b exp=0000", {bus.mem_ready, bus.if_ready, dbg_state});
         end
      end
      @(posedge clk);
      #1 bus.rw_ready = 1'b0;
   endtask

   initial begin
      bus.if_valid = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0; bus.if_size = '0;
      bus.mem_valid = 1'b0; bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_size = '0;
      bus.mem_data_write = '0;
      bus.rw_ready = 1'b0; bus.data_read = '0; bus.rw_resp = '0;
      test_reset();
      test_if_only();
      test_mem_priority();
      test_streak();
      test_lock();
      test_reset_mid();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
